fetch_buffer: RTL and testbench

//  Instruction prefetch stage sitting directly upstream of the instruction decoder/control path.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_buffer.sv | 125 ++++++++++++
 tb/tb_fetch_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of fetched {pc, inst} entries with flush.
// The head entry is read combinationally and reads as zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr_reg] <= push_data;
    end

    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: credit-limited sequential fetch, in-order buffering, redirect flush.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_dropped counters.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CW    = $clog2(DEPTH + MAX_OUTST + 1) + 1;

    logic [CW-1:0]    outst_reg, outst_next;
    logic [CW-1:0]    drop_reg, drop_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [31:0]      pc_tag_reg, pc_tag_next;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic [CW-1:0]    credit_used;
    logic             grant;
    logic             drop_word;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Buffered words plus live (not-to-be-dropped) requests must fit in the buffer.
    assign credit_used = CW'(fifo_count) + outst_reg - drop_reg;
    assign imem_req    = !reset && !redirect_valid
                         && (credit_used < CW'(DEPTH))
                         && (outst_reg < CW'(MAX_OUTST));
    assign imem_addr   = fetch_pc_reg;

    assign grant      = imem_req && imem_gnt;
    assign drop_word  = imem_rvalid && (drop_reg != '0);
    assign push       = imem_rvalid && !drop_word && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign push_entry = '{pc: pc_tag_reg, inst: imem_rdata};

    always_comb begin
        outst_next    = outst_reg + CW'(grant) - CW'(imem_rvalid);
        drop_next     = drop_reg - CW'(drop_word);
        fetch_pc_next = grant ? fetch_pc_reg + INST_BYTES : fetch_pc_reg;
        pc_tag_next   = push ? pc_tag_reg + INST_BYTES : pc_tag_reg;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            drop_next     = outst_next;
            fetch_pc_next = word_align(redirect_pc);
            pc_tag_next   = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_reg    <= '0;
            drop_reg     <= '0;
            fetch_pc_reg <= RESET_PC;
            pc_tag_reg   <= RESET_PC;
        end else begin
            outst_reg    <= outst_next;
            drop_reg     <= drop_next;
            fetch_pc_reg <= fetch_pc_next;
            pc_tag_reg   <= pc_tag_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_dropped_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_reg <= '0;
            perf_dropped_reg <= '0;
        end else begin
            if (push && (perf_fetched_reg != 32'hFFFF_FFFF))
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (imem_rvalid && !push && (perf_dropped_reg != 32'hFFFF_FFFF))
                perf_dropped_reg <= perf_dropped_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_dropped = perf_dropped_reg;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: an in-order memory model plus a queue-based
// reference of the instruction stream the decoder should see.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_buffer #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    mem_req_t    pend[$];
    exp_t        mq[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          epoch      = 0;
    int          last_due   = 0;
    logic [31:0] mfetch;
    logic [31:0] n_fetched;
    logic [31:0] n_dropped;
    int          ready_pct, gnt_pct, redir_pct, lat_min, lat_max;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic set_inputs();
        inst_ready     = ($urandom_range(99) < ready_pct);
        imem_gnt       = ($urandom_range(99) < gnt_pct);
        redirect_valid = ($urandom_range(99) < redir_pct);
        redirect_pc    = $urandom & 32'h0000_0FFF;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, apply the cycle's events to the model, advance.
    task automatic run_cycle();
        int       live;
        logic     exp_req;
        mem_req_t r;
        exp_t     e;
        @(negedge clk);
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_req = !redirect_valid && (mq.size() + live < DEPTH) && (pend.size() < MAX_OUTST);
        chk("imem_req", imem_req, exp_req);
        chk("inst_valid", inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_data", inst_data, mq[0].inst);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, n_fetched);
        chk("perf_dropped", perf_dropped, n_dropped);
`endif
        if (mq.size() != 0 && inst_ready) begin
            e = mq.pop_front();
            $display("cycle %0d: decode took pc=%h inst=%h", cyc, e.pc, e.inst);
        end
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !redirect_valid) begin
                mq.push_back('{pc: r.addr, inst: mem_word(r.addr)});
                n_fetched++;
            end else begin
                n_dropped++;
            end
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            mfetch = word_align(redirect_pc);
        end
        if (imem_req && imem_gnt) begin
            int lat = $urandom_range(lat_max, lat_min);
            int due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            chk("imem_addr", imem_addr, mfetch);
            pend.push_back('{addr: mfetch, epoch: epoch, due: due});
            last_due = due;
            mfetch   = mfetch + 32'd4;
            chk("outst_limit", 32'(pend.size() <= MAX_OUTST), 32'd1);
        end
        chk("buffer_limit", 32'(mq.size() <= DEPTH), 32'd1);
        @(posedge clk);
        cyc++;
        #1;
        set_inputs();
    endtask

    task automatic do_reset(input int cycles);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'h0);
        chk("rst_perf_dropped", perf_dropped, 32'h0);
`endif
        pend.delete();
        mq.delete();
        mfetch    = RESET_PC;
        last_due  = cyc;
        n_fetched = '0;
        n_dropped = '0;
        repeat (cycles) @(posedge clk);
        cyc += cycles;
        #1;
        reset = 1'b0;
        set_inputs();
    endtask

    initial begin
        ready_pct = 100; gnt_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
        do_reset(2);

        // Streaming with single-cycle memory.
        repeat (30) run_cycle();

        // Decoder stalls: buffer fills and fetch stops, then drains in order.
        ready_pct = 0;
        repeat (20) run_cycle();
        chk("stall_full", 32'(mq.size()), 32'(DEPTH));
        chk("stall_req", imem_req, 1'b0);
        ready_pct = 100;
        repeat (15) run_cycle();

        // Three-cycle memory with sporadic grants.
        lat_min = 3; lat_max = 3; gnt_pct = 70;
        repeat (40) run_cycle();

        // Directed redirects with requests in flight, including an unaligned target.
        ready_pct = 0; gnt_pct = 100;
        repeat (3) run_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        run_cycle();
        ready_pct = 100;
        repeat (12) run_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        run_cycle();
        repeat (12) run_cycle();

        // Fully random traffic with redirects, a mid-run reset, then more traffic.
        ready_pct = 60; gnt_pct = 60; redir_pct = 8; lat_min = 1; lat_max = 4;
        repeat (250) run_cycle();
        do_reset(2);
        repeat (250) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
